// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg
// EX/MEM pipeline register with a two-entry skid buffer (head + skid).
// The head entry drives the MEM-side outputs and the forwarding port. The skid
// entry catches one extra ALU result while MEM is stalled. Because ready_o
// depends only on registered state, there is no combinational ready path.
// Optional build macro: EXMEM_STALL_CNT_EN adds stall_cnt_o, a saturating
// count of cycles where the head is valid but MEM is not ready.
module ex_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              zero_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] alu_data_o,
  output logic              zero_o,
  output logic [DATA_W-1:0] st_data_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              fwd_en_o,
  output logic [REG_AW-1:0] fwd_addr_o,
  output logic [DATA_W-1:0] fwd_data_o
`ifdef EXMEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  // The MSB of the control bundle is reg_write.
  localparam int REG_WRITE_BIT = CTRL_W - 1;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic              zero;
    logic [DATA_W-1:0] st;
    logic [REG_AW-1:0] rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t head_q, skid_q, in_entry;
  logic   head_valid_q, skid_valid_q;
  logic   head_valid_d, skid_valid_d;
  logic   head_load_in, head_load_skid, skid_load_in;
  logic   accept, drain;

  assign ready_o = ~skid_valid_q;
  assign accept  = valid_i & ready_o & ~flush_i;
  assign drain   = head_valid_q & ready_i;

  // Build the incoming entry. A write to x0 has reg_write cleared at capture,
  // but the destination address itself is kept.
  always_comb begin
    in_entry      = '0;
    in_entry.alu  = alu_data_i;
    in_entry.zero = zero_i;
    in_entry.st   = st_data_i;
    in_entry.rd   = rd_addr_i;
    in_entry.ctrl = ctrl_i;
    if (rd_addr_i == '0) begin
      in_entry.ctrl[REG_WRITE_BIT] = 1'b0;
    end
  end

  // Decide where data moves this edge and compute the next occupancy. The
  // skid entry always refills the head before any newer entry, which keeps
  // ordering FIFO.
  always_comb begin
    head_load_in   = 1'b0;
    head_load_skid = 1'b0;
    skid_load_in   = 1'b0;
    head_valid_d   = head_valid_q;
    skid_valid_d   = skid_valid_q;
    if (flush_i) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (drain) begin
        head_load_skid = 1'b1;
        head_valid_d   = 1'b1;
        skid_valid_d   = 1'b0;
      end
    end else if (!head_valid_q || drain) begin
      head_load_in = accept;
      head_valid_d = accept;
    end else if (accept) begin
      skid_load_in = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  // Occupancy registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Head payload: loads from the input or from the skid. Otherwise it holds,
  // so outputs stay stable while MEM stalls.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_q <= '0;
    end else if (head_load_in) begin
      head_q <= in_entry;
    end else if (head_load_skid) begin
      head_q <= skid_q;
    end
  end

  // Skid payload: captures an entry only when the head is full and stalled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      skid_q <= '0;
    end else if (skid_load_in) begin
      skid_q <= in_entry;
    end
  end

  // Output and forwarding drive. Control is gated by valid, so a stale or
  // flushed head never looks like a live instruction.
  always_comb begin
    valid_o    = head_valid_q;
    alu_data_o = head_q.alu;
    zero_o     = head_q.zero;
    st_data_o  = head_q.st;
    rd_addr_o  = head_q.rd;
    ctrl_o     = head_valid_q ? head_q.ctrl : '0;
    fwd_en_o   = head_valid_q & head_q.ctrl[REG_WRITE_BIT] & (head_q.rd != '0);
    fwd_addr_o = head_q.rd;
    fwd_data_o = head_q.alu;
  end

`ifdef EXMEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating MEM-stall counter. Flush does not clear it; only reset does.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (head_valid_q && !ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb_ex_mem_skid_reg
// Directed bench for ex_mem_skid_reg. Covers reset, backpressure, streaming,
// x0 writes, flush, and (with EXMEM_STALL_CNT_EN) the stall counter.
module tb_ex_mem_skid_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] alu_data_i;
  logic        zero_i;
  logic [31:0] st_data_i;
  logic [4:0]  rd_addr_i;
  logic [3:0]  ctrl_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] alu_data_o;
  logic        zero_o;
  logic [31:0] st_data_o;
  logic [4:0]  rd_addr_o;
  logic [3:0]  ctrl_o;
  logic        fwd_en_o;
  logic [4:0]  fwd_addr_o;
  logic [31:0] fwd_data_o;
`ifdef EXMEM_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  ex_mem_skid_reg dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .alu_data_i (alu_data_i),
    .zero_i     (zero_i),
    .st_data_i  (st_data_i),
    .rd_addr_i  (rd_addr_i),
    .ctrl_i     (ctrl_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .alu_data_o (alu_data_o),
    .zero_o     (zero_o),
    .st_data_o  (st_data_o),
    .rd_addr_o  (rd_addr_o),
    .ctrl_o     (ctrl_o),
    .fwd_en_o   (fwd_en_o),
    .fwd_addr_o (fwd_addr_o),
    .fwd_data_o (fwd_data_o)
`ifdef EXMEM_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic z,
                               input logic [31:0] st, input logic [4:0] rd,
                               input logic [3:0] ctrl);
    valid_i    = v;
    alu_data_i = alu;
    zero_i     = z;
    st_data_i  = st;
    rd_addr_i  = rd;
    ctrl_i     = ctrl;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i   = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 4'b0000);
    #3;
    checkOutput("por_valid", valid_o, 1'b0);
    checkOutput("por_ready", ready_o, 1'b1);
    checkOutput("por_ctrl", ctrl_o, 4'b0000);
    checkOutput("por_fwd_en", fwd_en_o, 1'b0);
    checkOutput("por_alu", alu_data_o, 32'h0);
    step();
    rst_i = 1'b1;

    // Fill the skid, then apply an asynchronous reset mid-cycle.
    ready_i = 1'b0;
    applyStimulus(1'b1, 32'h55, 1'b0, 32'h1, 5'd1, 4'b1000);
    step();
    applyStimulus(1'b1, 32'h66, 1'b0, 32'h2, 5'd2, 4'b1000);
    step();
    checkOutput("pre_rst_ready", ready_o, 1'b0);
    checkOutput("pre_rst_valid", valid_o, 1'b1);
    rst_i = 1'b0;
    #1;
    checkOutput("rst_valid", valid_o, 1'b0);
    checkOutput("rst_ready", ready_o, 1'b1);
    checkOutput("rst_ctrl", ctrl_o, 4'b0000);
    checkOutput("rst_fwd_en", fwd_en_o, 1'b0);
    rst_i = 1'b1;
    applyStimulus(1'b1, 32'h7, 1'b0, 32'h0, 5'd3, 4'b1000);
    step();
    checkOutput("post_rst_valid", valid_o, 1'b1);
    checkOutput("post_rst_alu", alu_data_o, 32'h7);
    checkOutput("post_rst_fwd_en", fwd_en_o, 1'b1);
    checkOutput("post_rst_fwd_addr", fwd_addr_o, 5'd3);
    checkOutput("post_rst_fwd_data", fwd_data_o, 32'h7);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 4'b0000);
    ready_i = 1'b1;
    step();
    checkOutput("post_rst_drained", valid_o, 1'b0);

    // Backpressure: A goes to the head, B to the skid, and C waits.
    ready_i = 1'b0;
    applyStimulus(1'b1, 32'h11, 1'b1, 32'hA1, 5'd5, 4'b1000);
    step();
    checkOutput("bp_a_alu", alu_data_o, 32'h11);
    checkOutput("bp_a_ready", ready_o, 1'b1);
    applyStimulus(1'b1, 32'h22, 1'b0, 32'hB2, 5'd6, 4'b1010);
    step();
    checkOutput("bp_b_ready", ready_o, 1'b0);
    checkOutput("bp_head_a", alu_data_o, 32'h11);
    checkOutput("bp_head_a_zero", zero_o, 1'b1);
    applyStimulus(1'b1, 32'h33, 1'b0, 32'hC3, 5'd7, 4'b1000);
    step();
    checkOutput("bp_hold_alu", alu_data_o, 32'h11);
    checkOutput("bp_hold_st", st_data_o, 32'hA1);
    checkOutput("bp_hold_rd", rd_addr_o, 5'd5);
    checkOutput("bp_hold_ready", ready_o, 1'b0);
    ready_i = 1'b1;
    step();
    checkOutput("bp_b_alu", alu_data_o, 32'h22);
    checkOutput("bp_b_ctrl", ctrl_o, 4'b1010);
    checkOutput("bp_b_zero", zero_o, 1'b0);
    checkOutput("bp_ready_back", ready_o, 1'b1);
    step();
    checkOutput("bp_c_alu", alu_data_o, 32'h33);
    checkOutput("bp_c_valid", valid_o, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 4'b0000);
    step();
    checkOutput("bp_empty", valid_o, 1'b0);
    checkOutput("bp_empty_ctrl", ctrl_o, 4'b0000);

    // Streaming with MEM always ready.
    ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0, 32'(i * 16), 5'(i + 8), 4'b1000);
      step();
      checkOutput($sformatf("stream_alu_%0d", i), alu_data_o, 32'(i));
      checkOutput($sformatf("stream_valid_%0d", i), valid_o, 1'b1);
      checkOutput($sformatf("stream_ready_%0d", i), ready_o, 1'b1);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 4'b0000);
    step();
    checkOutput("stream_end", valid_o, 1'b0);

    // A write to x0 must never enable forwarding or reg_write.
    ready_i = 1'b0;
    applyStimulus(1'b1, 32'hDEAD, 1'b0, 32'h0, 5'd0, 4'b1000);
    step();
    checkOutput("x0_ctrl", ctrl_o, 4'b0000);
    checkOutput("x0_fwd_en", fwd_en_o, 1'b0);
    checkOutput("x0_alu", alu_data_o, 32'hDEAD);
    checkOutput("x0_valid", valid_o, 1'b1);
    applyStimulus(1'b1, 32'hBEEF, 1'b0, 32'h0, 5'd0, 4'b1111);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 4'b0000);
    ready_i = 1'b1;
    step();
    checkOutput("x0_skid_ctrl", ctrl_o, 4'b0111);
    checkOutput("x0_skid_alu", alu_data_o, 32'hBEEF);
    step();
    checkOutput("x0_empty", valid_o, 1'b0);

    // Flush with the skid full and a new entry arriving.
    ready_i = 1'b0;
    applyStimulus(1'b1, 32'hAAAA, 1'b0, 32'h0, 5'd9, 4'b1000);
    step();
    applyStimulus(1'b1, 32'hBBBB, 1'b0, 32'h0, 5'd10, 4'b1000);
    step();
    checkOutput("fl_pre_ready", ready_o, 1'b0);
    applyStimulus(1'b1, 32'hCCCC, 1'b0, 32'h0, 5'd11, 4'b1000);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checkOutput("fl_valid", valid_o, 1'b0);
    checkOutput("fl_ready", ready_o, 1'b1);
    checkOutput("fl_ctrl", ctrl_o, 4'b0000);
    checkOutput("fl_fwd_en", fwd_en_o, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 4'b0000);
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("fl_quiet_%0d", i), valid_o, 1'b0);
    end

`ifdef EXMEM_STALL_CNT_EN
    // Reset the stall counter, then stall a single head entry.
    rst_i = 1'b0;
    #1;
    checkOutput("sc_reset", stall_cnt_o, 32'd0);
    rst_i = 1'b1;
    ready_i = 1'b0;
    applyStimulus(1'b1, 32'h5, 1'b0, 32'h0, 5'd4, 4'b1000);
    step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 4'b0000);
    checkOutput("sc_start", stall_cnt_o, 32'd0);
    for (int i = 0; i < 5; i++) step();
    checkOutput("sc_five", stall_cnt_o, 32'd5);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checkOutput("sc_flush_cnt", stall_cnt_o, 32'd6);
    step();
    checkOutput("sc_idle_hold", stall_cnt_o, 32'd6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- EX/MEM pipeline register placed directly downstream of the execute-stage ALU.
- Captures the ALU result, the store data, the destination register and the MEM/WB control bits.
- Uses valid/ready handshakes on both sides, backed by a 2-entry skid buffer, so a MEM-stage stall never drops an ALU result.
- Exports a forwarding port from the head entry to the EX-stage operand muxes.

Parameters:
DATA_W, 32, width of ALU result and store data
REG_AW, 5, register-file address width
CTRL_W, 4, MEM/WB control bundle width {reg_write, mem_to_reg, mem_read, mem_write}

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
flush_i  in  1  squash all held and incoming entries (branch/exception)
valid_i  in  1  EX stage presents a result this cycle
ready_o  out  1  block can accept an entry this cycle
alu_data_i  in  DATA_W  ALU result
zero_i  in  1  ALU zero flag
st_data_i  in  DATA_W  store data (rs2 after forwarding)
rd_addr_i  in  REG_AW  destination register
ctrl_i  in  CTRL_W  control bundle
valid_o  out  1  head entry valid toward MEM
ready_i  in  1  MEM stage accepts head this cycle
alu_data_o  out  DATA_W  head ALU result
zero_o  out  1  head zero flag
st_data_o  out  DATA_W  head store data
rd_addr_o  out  REG_AW  head destination
ctrl_o  out  CTRL_W  head control bundle
fwd_en_o  out  1  valid_o & ctrl_o[3] & (rd_addr_o != 0)
fwd_addr_o  out  REG_AW  equals rd_addr_o
fwd_data_o  out  DATA_W  equals alu_data_o

Behaviour:
- Storage: head register (drives outputs) and skid register; each has its own valid bit. All state is registered; no combinational path from ready_i to ready_o.
- Reset (rst_i=0, asynchronous): both valids=0; all data, addr and ctrl outputs=0; zero_o=0; fwd_en_o=0; ready_o=1.
- ready_o = ~skid_valid (registered state).
- Accept = valid_i & ready_o & ~flush_i. Drain = valid_o & ready_i.
- Latency: an entry accepted at edge N appears on the outputs after edge N (1 cycle) if head is empty or draining at N.
- Per-edge cases:
  - Head empty: accepted entry goes to head.
  - Head full, draining, skid empty: accepted entry goes to head.
  - Head full, not draining: accepted entry goes to skid; ready_o=0 next cycle.
  - Head draining, skid full: skid moves to head; skid cleared; ready_o=1 next cycle. No accept is possible this cycle, since ready_o=0.
  - Head draining, nothing accepted, skid empty: head_valid=0.
- Ordering: strict FIFO; the skid entry always precedes any newer entry.
- Write to x0: on capture, if rd_addr_i==0 then stored ctrl[3] (reg_write) is forced to 0. rd_addr is still stored.
- Flush (synchronous): both valids cleared at the edge. The incoming entry is dropped even if valid_i=1, and a same-cycle drain is irrelevant. Data fields may hold stale values but valid_o=0 and fwd_en_o=0. ready_o=1 next cycle.
- Holding: while valid_o=1 and ready_i=0, all head outputs are stable.
- ready_i while valid_o=0: ignored.
- Empty head: data fields are don't-care; control outputs are gated, so ctrl_o=0 whenever valid_o=0.

Optional Feature:
- Macro EXMEM_STALL_CNT_EN. When defined, adds output stall_cnt_o[31:0].
- stall_cnt_o counts cycles with valid_o=1 and ready_i=0. It saturates at 32'hFFFFFFFF, is reset to 0 by rst_i, and is unaffected by flush_i.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_i=0 mid-traffic with skid full -> immediately valid_o=0, ready_o=1, ctrl_o=0, fwd_en_o=0; release, then push alu=0x0000_0007, rd=3, ctrl=4'b1000 -> next cycle valid_o=1, alu_data_o=7, fwd_en_o=1, fwd_addr_o=3.
- Backpressure: ready_i=0, push A=0x11 then B=0x22 -> after B, ready_o=0 and head=A; raise ready_i -> A out, then B out on consecutive cycles, ready_o=1 after skid empties, no loss or reorder.
- Streaming: ready_i=1, push 0x1..0x8 back-to-back -> outputs 0x1..0x8 one per cycle with 1-cycle latency, ready_o constantly 1.
- x0 write: push rd=0, ctrl=4'b1000, alu=0xDEAD -> ctrl_o=4'b0000, fwd_en_o=0, alu_data_o=0xDEAD.
- Flush: skid full, ready_i=0, valid_i=1, flush_i=1 -> next cycle valid_o=0, ready_o=1; no held or incoming entry ever emerges.
- With EXMEM_STALL_CNT_EN: hold valid_o=1, ready_i=0 for 5 cycles -> stall_cnt_o=5; preload near max -> sticks at 0xFFFFFFFF.
